// File: rtl/dac_driver.sv
// -----------------------------------------------------------------------------
// dac_driver
//   Transmit path to an external parallel 8-bit DAC. Samples arrive on a
//   valid/ready stream, are buffered in a small FIFO, and are presented on the
//   DAC pins together with a generated DAC clock. The DAC clock toggles on
//   every strobe of a free-running divider. A new sample is popped only on the
//   strobe that drives the clock low, so the data is settled for a full
//   half-period around every rising edge.
//
// Ports
//   iClk           in   system clock
//   iRst           in   asynchronous, active-high reset
//   iDac_Data      in   8-bit sample to transmit
//   iData_Valid    in   iDac_Data is valid this cycle
//   oReady         out  FIFO can accept a word (not full)
//   oDAC_Data      out  registered data to the DAC pins
//   oDAC_CLK       out  registered DAC clock; the DAC latches on its rising edge
//   oFifo_Level    out  number of words currently stored
//   oUnderrun      out  sticky flag: an update found the FIFO empty
//   iClr_Underrun  in   synchronous clear of oUnderrun
// -----------------------------------------------------------------------------
module dac_driver #(
  parameter int         pClkCycPerStrobeCyc = 5,
  parameter int         pFifoDepth          = 16,
  parameter logic [7:0] pIdleCode           = 8'h80
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [7:0]                    iDac_Data,
  input  logic                          iData_Valid,
  output logic                          oReady,
  output logic [7:0]                    oDAC_Data,
  output logic                          oDAC_CLK,
  output logic [$clog2(pFifoDepth):0]   oFifo_Level,
  output logic                          oUnderrun,
  input  logic                          iClr_Underrun
);

  localparam int CW = (pClkCycPerStrobeCyc > 1) ? $clog2(pClkCycPerStrobeCyc) : 1;
  localparam int AW = $clog2(pFifoDepth);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(pClkCycPerStrobeCyc - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(pFifoDepth);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Strobe divider
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  // DAC output registers
  logic          dac_clk_q, dac_clk_d;
  logic [7:0]    dac_data_q, dac_data_d;
  logic          underrun_q, underrun_d;

  // FIFO state
  logic [7:0]    mem_q [pFifoDepth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic upd_s;
  logic pop_s;

  // Full/empty come from the registered level, so a word written on the same
  // edge as an update strobe is never visible to that update (no bypass).
  assign full_s  = (level_q == LVL_FULL);
  assign empty_s = (level_q == LVL_ZERO);
  assign push_s  = iData_Valid & ~full_s;
  // The update strobe is the one that takes the DAC clock from high to low.
  assign upd_s   = strobe_q & dac_clk_q;
  assign pop_s   = upd_s & ~empty_s;

  // Strobe divider: counter wraps at pClkCycPerStrobeCyc-1, strobe follows the wrap.
  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d    = {CW{1'b0}};
      strobe_d = 1'b1;
    end else begin
      cnt_d    = cnt_q + CNT_ONE;
      strobe_d = 1'b0;
    end
  end

  // DAC clock toggle, data update on the falling strobe, sticky underrun.
  always_comb begin
    dac_clk_d  = dac_clk_q;
    dac_data_d = dac_data_q;
    underrun_d = underrun_q;
    if (strobe_q) begin
      dac_clk_d = ~dac_clk_q;
    end else begin
      dac_clk_d = dac_clk_q;
    end
    if (pop_s) begin
      dac_data_d = mem_q[rd_ptr_q];
    end else begin
      dac_data_d = dac_data_q;
    end
    // Set has priority over clear when both happen on one edge.
    if (upd_s && empty_s) begin
      underrun_d = 1'b1;
    end else if (iClr_Underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // FIFO pointer and level next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt_q      <= {CW{1'b0}};
      strobe_q   <= 1'b0;
      dac_clk_q  <= 1'b0;
      dac_data_q <= pIdleCode;
      underrun_q <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      strobe_q   <= strobe_d;
      dac_clk_q  <= dac_clk_d;
      dac_data_q <= dac_data_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers are reset.
  always_ff @(posedge iClk) begin
    if (push_s && !iRst) begin
      mem_q[wr_ptr_q] <= iDac_Data;
    end
  end

  assign oReady      = ~full_s;
  assign oDAC_Data   = dac_data_q;
  assign oDAC_CLK    = dac_clk_q;
  assign oFifo_Level = level_q;
  assign oUnderrun   = underrun_q;

endmodule

// File: tb/tb_dac_driver.sv
// -----------------------------------------------------------------------------
// tb_dac_driver
//   Self-checking bench for dac_driver. The driver pushes every accepted word
//   (with the edge number it was accepted on) into a reference queue; a
//   monitor derives the DAC clock and update edges from the edge count alone
//   and pops/compares on each update. A second instance with a 3-cycle strobe
//   checks the clock shape and data stability.
// -----------------------------------------------------------------------------
module tb_dac_driver;

  localparam int P1    = 5;
  localparam int P2    = 3;
  localparam int DEPTH = 16;

  logic       iClk;
  logic       iRst;
  logic [7:0] iDac_Data;
  logic       iData_Valid;
  logic       oReady;
  logic [7:0] oDAC_Data;
  logic       oDAC_CLK;
  logic [4:0] oFifo_Level;
  logic       oUnderrun;
  logic       iClr_Underrun;

  logic [7:0] d2_in;
  logic       v2_in;
  logic       clr2_in;
  logic       ready2;
  logic [7:0] data2;
  logic       clk2;
  logic [4:0] level2;
  logic       und2;

  dac_driver #(.pClkCycPerStrobeCyc(P1), .pFifoDepth(DEPTH), .pIdleCode(8'h80)) dut (
    .iClk(iClk), .iRst(iRst), .iDac_Data(iDac_Data), .iData_Valid(iData_Valid),
    .oReady(oReady), .oDAC_Data(oDAC_Data), .oDAC_CLK(oDAC_CLK),
    .oFifo_Level(oFifo_Level), .oUnderrun(oUnderrun), .iClr_Underrun(iClr_Underrun)
  );

  dac_driver #(.pClkCycPerStrobeCyc(P2), .pFifoDepth(DEPTH), .pIdleCode(8'h80)) dut2 (
    .iClk(iClk), .iRst(iRst), .iDac_Data(d2_in), .iData_Valid(v2_in),
    .oReady(ready2), .oDAC_Data(data2), .oDAC_CLK(clk2),
    .oFifo_Level(level2), .oUnderrun(und2), .iClr_Underrun(clr2_in)
  );

  typedef struct {
    logic [7:0] d;
    int         c;
  } ent_t;

  ent_t       q[$];
  int         cyc;
  int         cyc2;
  logic [7:0] last_m;
  bit         und_m;
  bit         set_u;
  bit         clr_smp;
  bit         saw_full;
  logic       prev_clk2;
  logic [7:0] prev_d2;
  int         n_chk;
  int         n_fail;

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // DAC clock level after edge k (k edges since reset release).
  function automatic int exp_clk(input int k, input int p);
    if (k < p + 1) return 0;
    return ((k - 1) / p) % 2;
  endfunction

  // Edge k is an update (falling DAC clock) edge.
  function automatic bit is_upd(input int k, input int p);
    return (k > 1) && ((k - 1) % p == 0) && (((k - 1) / p) % 2 == 0);
  endfunction

  // Scoreboard monitor for the main instance.
  always @(posedge iClk) begin
    clr_smp = iClr_Underrun;
    if (iRst) begin
      cyc = 0;
    end else begin
      cyc++;
      set_u = 1'b0;
      if (is_upd(cyc, P1)) begin
        if (q.size() > 0 && q[0].c < cyc) begin
          last_m = q[0].d;
          void'(q.pop_front());
        end else begin
          set_u = 1'b1;
        end
      end
      if (set_u) und_m = 1'b1;
      else if (clr_smp) und_m = 1'b0;
      #1;
      chk("dac_clk", int'(oDAC_CLK), exp_clk(cyc, P1));
      chk("dac_data", int'(oDAC_Data), int'(last_m));
      chk("underrun", int'(oUnderrun), int'(und_m));
      chk("level", int'(oFifo_Level), q.size());
      chk("ready", int'(oReady), (q.size() < DEPTH) ? 1 : 0);
    end
  end

  // Second instance: constant writer with an incrementing value.
  initial begin
    d2_in   = 8'h00;
    v2_in   = 1'b1;
    clr2_in = 1'b0;
    forever begin
      @(negedge iClk);
      d2_in = d2_in + 8'h01;
    end
  end

  // Clock-shape and data-stability checks on the 3-cycle instance.
  always @(posedge iClk) begin
    if (iRst) cyc2 = 0;
    else cyc2++;
    #1;
    if (!iRst) begin
      chk("dac2_clk", int'(clk2), exp_clk(cyc2, P2));
      chk("dac2_stable", ((data2 != prev_d2) && !(prev_clk2 && !clk2)) ? 1 : 0, 0);
      chk("dac2_underrun", int'(und2), 0);
      chk("dac2_ready", int'(ready2), (level2 != 5'd16) ? 1 : 0);
    end
    prev_clk2 = clk2;
    prev_d2   = data2;
  end

  task automatic write_word(input logic [7:0] d);
    int w;
    w = 0;
    iDac_Data   = d;
    iData_Valid = 1'b1;
    while (oReady !== 1'b1 && w < 1000) begin
      saw_full = 1'b1;
      @(negedge iClk);
      w++;
    end
    if (w >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL write_timeout at t=%0t: ready stayed %0b, required 1", $time, oReady);
    end else begin
      q.push_back('{d: d, c: cyc + 1});
    end
    @(negedge iClk);
    iData_Valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst          = 1'b1;
    iData_Valid   = 1'b0;
    iClr_Underrun = 1'b0;
    q.delete();
    last_m = 8'h80;
    und_m  = 1'b0;
    #1;
    chk("rst_data", int'(oDAC_Data), 32'h80);
    chk("rst_clk", int'(oDAC_CLK), 0);
    chk("rst_level", int'(oFifo_Level), 0);
    chk("rst_ready", int'(oReady), 1);
    chk("rst_underrun", int'(oUnderrun), 0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at t=%0t: bench did not finish, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_chk         = 0;
    n_fail        = 0;
    cyc           = 0;
    cyc2          = 0;
    saw_full      = 1'b0;
    prev_clk2     = 1'b0;
    prev_d2       = 8'h80;
    last_m        = 8'h80;
    und_m         = 1'b0;
    iRst          = 1'b1;
    iDac_Data     = 8'h00;
    iData_Valid   = 1'b0;
    iClr_Underrun = 1'b0;

    // Power-on reset, then reset mid-stream with five words buffered.
    do_reset();
    for (int i = 1; i <= 5; i++) write_word(8'(i));
    do_reset();

    // Single write, then underrun and its clear.
    write_word(8'hA5);
    repeat (25) @(negedge iClk);
    chk("underrun_set", int'(oUnderrun), 1);
    while (is_upd(cyc + 1, P1)) @(negedge iClk);
    iClr_Underrun = 1'b1;
    @(negedge iClk);
    iClr_Underrun = 1'b0;
    chk("underrun_clr", int'(oUnderrun), 0);
    w = 0;
    while (!is_upd(cyc + 1, P1) && w < 40) begin
      @(negedge iClk);
      w++;
    end
    iClr_Underrun = 1'b1;
    @(negedge iClk);
    iClr_Underrun = 1'b0;
    chk("underrun_set_wins", int'(oUnderrun), 1);
    repeat (3) @(negedge iClk);

    // Fill to full with an incrementing sequence, then drain.
    do_reset();
    saw_full = 1'b0;
    for (int i = 0; i < 40; i++) write_word(8'(i));
    chk("saw_full", int'(saw_full), 1);
    repeat (420) @(negedge iClk);
    chk("drained_level", int'(oFifo_Level), 0);

    // Pointer wrap with random gaps while the output drains.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge iClk);
      write_word(8'h10 + 8'(i));
    end
    chk("no_underrun", int'(oUnderrun), 0);
    repeat (420) @(negedge iClk);
    chk("wrap_level", int'(oFifo_Level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_driver.md
# dac_driver

Transmit-side counterpart to the scope ADC capture path. It accepts 8-bit samples on a valid/ready stream from the internal 100 MHz fabric and buffers them in a small FIFO. It drives an external parallel 8-bit DAC with a generated DAC clock, built from the same strobe-divider scheme the ADC side uses. It sits between the waveform source (pattern generator or loopback from the capture path) and the DAC pins.

## Interface
- pClkCycPerStrobeCyc, 5, iClk cycles per strobe. Must be ≥ 2. DAC clock = iClk / (2·pClkCycPerStrobeCyc), i.e. 10 MHz at default.
- pFifoDepth, 16, FIFO entries. Power of two, ≥ 4.
- pIdleCode, 8'h80, value driven on oDAC_Data from reset until the first sample is output (midscale).

- iClk  in  1  100 MHz system clock
- iRst  in  1  asynchronous, active-high reset
- iDac_Data  in  8  sample to transmit
- iData_Valid  in  1  iDac_Data is valid this cycle
- oReady  out  1  FIFO can accept a word; equals !full
- oDAC_Data  out  8  registered data to DAC pins
- oDAC_CLK  out  1  registered DAC clock; DAC latches on rising edge
- oFifo_Level  out  clog2(pFifoDepth)+1  words currently stored
- oUnderrun  out  1  sticky: a DAC update found the FIFO empty
- iClr_Underrun  in  1  synchronous clear of oUnderrun

## Operation
- **Reset state (async, while iRst=1):**
  - oDAC_Data=pIdleCode, oDAC_CLK=0, oUnderrun=0.
  - FIFO empty, so oFifo_Level=0 and oReady=1.
  - Strobe counter=0, strobe register=0.
  - Writes presented during reset are ignored.
- **Strobe generator:**
  - Counter runs 0..pClkCycPerStrobeCyc-1 and wraps.
  - The strobe register is 1 in the cycle after the counter wraps, otherwise 0.
  - One strobe occurs every pClkCycPerStrobeCyc cycles.
- **DAC clock and update:**
  - On each strobe, oDAC_CLK toggles.
  - Strobe with oDAC_CLK=0: the clock rises; data is unchanged.
  - Strobe with oDAC_CLK=1 (the "update strobe"): the clock falls.
    - If the FIFO is not empty, the head word is popped and registered onto oDAC_Data in the same edge.
    - If the FIFO is empty, oDAC_Data holds its previous value and oUnderrun is set to 1.
- **Write handshake:**
  - A word is accepted on an iClk edge where iData_Valid=1 and oReady=1.
  - iDac_Data is ignored otherwise.
  - There is no bypass: a word accepted on the same edge as an update strobe on an empty FIFO is not popped. That update is an underrun.
- **Simultaneous push and pop:** allowed when not full and not empty; oFifo_Level is unchanged.
  - When full, oReady=0, so no push occurs. A pop still happens on an update strobe.
- **Pointers:** read and write pointers wrap modulo pFifoDepth. Full and empty are derived from oFifo_Level, or from an extra pointer bit.
- **Ordering:** samples leave in exactly the order accepted, with none lost or duplicated, except for the hold-on-underrun behaviour.
- **oUnderrun:**
  - Cleared by iClr_Underrun=1 on a clock edge.
  - If a set condition and a clear occur on the same edge, set wins.
- **Stability:** oDAC_Data changes only on update strobes, i.e. falling oDAC_CLK.

## Timing
- **After reset release:**
  - The first strobe takes effect on iClk edge pClkCycPerStrobeCyc+1, where oDAC_CLK rises.
  - The first update strobe is pClkCycPerStrobeCyc edges later.
- **DAC clock shape:** oDAC_CLK is high and low for pClkCycPerStrobeCyc cycles each (50% duty at default).
- **DAC setup/hold:** oDAC_Data is stable pClkCycPerStrobeCyc cycles before and after each rising oDAC_CLK.
- **FIFO level timing:**
  - Write accepted at edge k: oFifo_Level increments at edge k.
  - The word is eligible for output at the first update strobe at edge ≥ k+1.
- **oReady:** combinational from the full flag (registered level). It drops in the cycle after the write that fills the FIFO.
- **Throughput:** sustained rate is one sample per 2·pClkCycPerStrobeCyc cycles (10 MS/s at default).
- **Reset mid-operation:**
  - Outputs return to their reset values immediately (async).
  - FIFO contents are discarded.
  - The strobe phase restarts from 0 on release.

## Test plan
- **Reset values:** assert iRst mid-stream with the FIFO holding 5 words -> oDAC_Data=8'h80, oDAC_CLK=0, oFifo_Level=0, oReady=1, oUnderrun=0 immediately. After release, the first oDAC_CLK rise occurs at edge 6.
- **Single write:** write 8'hA5 once after reset -> oDAC_Data=8'hA5 on the first falling oDAC_CLK (edge 11 at default). oFifo_Level goes 1->0 there. On the next update, oDAC_Data holds 8'hA5 and oUnderrun=1.
- **Fill to full:** hold iData_Valid=1 with an incrementing 8'h00.. sequence -> oReady=0 when oFifo_Level=16. Samples then leave one per 10 cycles. Values are 0,1,2,… with no gaps or duplicates, and word 16 is accepted only after the first pop.
- **Pointer wrap and ordering:** write 40 words 8'h10..8'h37 with random valid gaps while the output drains -> oDAC_Data shows exactly 8'h10..8'h37 in order, with oUnderrun=0 as long as the writer keeps up.
- **Underrun clear:** produce an underrun, then pulse iClr_Underrun -> oUnderrun goes 1->0. Clear on the same edge as a new underrun -> oUnderrun stays 1.
- **Clock shape:** pClkCycPerStrobeCyc=3 -> oDAC_CLK has a period of 6 cycles with 3 high and 3 low, and oDAC_Data changes only on its falling edges.
